// File: rtl/led_scheduler_if.sv
// ---------------------------------------------------------------------------
// led_scheduler_if
// Bundles the display-source side of the LED scheduler: per-source requests
// and patterns, the flash request, and the grant / slot_done / LED results.
//
// Signals
//   req[2:0]        sources -> scheduler  level request per source
//   src0/1/2_led    sources -> scheduler  per-source LED pattern
//   flash_req       sources -> scheduler  one-cycle flash request pulse
//   flash_pattern   sources -> scheduler  pattern captured with flash_req
//   grant[2:0]      scheduler -> sources  one-hot grant, zero when idle
//   slot_done       scheduler -> sources  one-cycle pulse at end of a slot
//   led[7:0]        scheduler -> pins     registered LED drive
//
// Modports
//   master : the source / pin side (drives requests, observes results)
//   slave  : the scheduler itself
// ---------------------------------------------------------------------------
interface led_scheduler_if;
   logic [2:0] req;
   logic [7:0] src0_led;
   logic [7:0] src1_led;
   logic [7:0] src2_led;
   logic       flash_req;
   logic [7:0] flash_pattern;
   logic [2:0] grant;
   logic       slot_done;
   logic [7:0] led;

   modport master (
      output req,
      output src0_led,
      output src1_led,
      output src2_led,
      output flash_req,
      output flash_pattern,
      input  grant,
      input  slot_done,
      input  led
   );

   modport slave (
      input  req,
      input  src0_led,
      input  src1_led,
      input  src2_led,
      input  flash_req,
      input  flash_pattern,
      output grant,
      output slot_done,
      output led
   );
endinterface

// File: rtl/led_scheduler.sv
// ---------------------------------------------------------------------------
// led_scheduler
// Time-slices the 8-LED bank between three display sources (letter scroller,
// equalizer band meter, debug status) with round-robin grants of a fixed
// slice length, early release when a source drops its request, and a
// preemptive one-shot flash that freezes the running slice and resumes it.
//
// Parameters
//   SLICE_CYCLES  grant length per slot in clk cycles (>= 2)
//   FLASH_CYCLES  flash display length in clk cycles (>= 2)
//
// Ports
//   clk   system clock
//   rst   synchronous, active-high reset
//   bus   led_scheduler_if.slave (requests, patterns, grant, slot_done, led)
//
// State table
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | nothing granted, LED driven to 0, waiting for any request
//   ST_SERVE | one source granted, its pattern copied to LED every cycle
//   ST_FLASH | flash pattern on LED, grant 0, slice count and owner frozen
// ---------------------------------------------------------------------------
module led_scheduler #(
   parameter int SLICE_CYCLES = 275_500_000,
   parameter int FLASH_CYCLES = 25_000_000
) (
   input  logic           clk,
   input  logic           rst,
   led_scheduler_if.slave bus
);

   localparam int SW = $clog2(SLICE_CYCLES);
   localparam int FW = $clog2(FLASH_CYCLES);
   localparam logic [SW-1:0] SLICE_LAST = SW'(SLICE_CYCLES - 1);
   localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SERVE = 2'd1,
      ST_FLASH = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [2:0]      grant_q, grant_d;
   logic [2:0]      saved_q, saved_d;
   logic            slot_done_q, slot_done_d;
   logic [7:0]      led_q, led_d;
   logic [1:0]      last_q, last_d;
   logic [SW-1:0]   slice_cnt_q, slice_cnt_d;
   logic [FW-1:0]   flash_cnt_q, flash_cnt_d;

   logic [1:0]      cand1, cand2;
   logic [1:0]      win_idx;
   logic            win_vld;
   logic [2:0]      win_oh;
   logic            slice_end;
   logic            released;

   function automatic logic [7:0] pick_led(input logic [2:0] oh,
                                           input logic [7:0] a,
                                           input logic [7:0] b,
                                           input logic [7:0] c);
      return ({8{oh[0]}} & a) | ({8{oh[1]}} & b) | ({8{oh[2]}} & c);
   endfunction

   // Round-robin search starting just after the last-served source; the
   // last-served source is checked last so it only wins when it is alone.
   always_comb begin
      cand1   = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
      cand2   = (cand1  == 2'd2) ? 2'd0 : cand1  + 2'd1;
      win_vld = 1'b1;
      win_idx = last_q;
      if (bus.req[cand1]) begin
         win_idx = cand1;
      end else if (bus.req[cand2]) begin
         win_idx = cand2;
      end else if (bus.req[last_q]) begin
         win_idx = last_q;
      end else begin
         win_vld = 1'b0;
      end
      win_oh = 3'b001 << win_idx;
   end

   assign slice_end = (slice_cnt_q == SLICE_LAST);
   assign released  = ((bus.req & grant_q) == 3'b000);

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      saved_d     = saved_q;
      slot_done_d = 1'b0;
      led_d       = led_q;
      last_d      = last_q;
      slice_cnt_d = slice_cnt_q;
      flash_cnt_d = flash_cnt_q;

      if (bus.flash_req) begin
         // Flash wins over any expiry or release seen this cycle; those are
         // re-evaluated when the flash ends because the slice is frozen.
         state_d     = ST_FLASH;
         led_d       = bus.flash_pattern;
         grant_d     = 3'b000;
         flash_cnt_d = '0;
         if (state_q == ST_SERVE) begin
            saved_d = grant_q;
         end else if (state_q == ST_IDLE) begin
            saved_d = 3'b000;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               led_d   = 8'h00;
               grant_d = 3'b000;
               if (win_vld) begin
                  state_d     = ST_SERVE;
                  grant_d     = win_oh;
                  slice_cnt_d = '0;
                  last_d      = win_idx;
               end
            end

            ST_SERVE: begin
               led_d = pick_led(grant_q, bus.src0_led, bus.src1_led, bus.src2_led);
               if (released || slice_end) begin
                  slot_done_d = 1'b1;
                  slice_cnt_d = '0;
                  if (win_vld) begin
                     grant_d = win_oh;
                     last_d  = win_idx;
                  end else begin
                     state_d = ST_IDLE;
                     grant_d = 3'b000;
                  end
               end else begin
                  slice_cnt_d = slice_cnt_q + 1'b1;
               end
            end

            ST_FLASH: begin
               if (flash_cnt_q == FLASH_LAST) begin
                  if ((bus.req & saved_q) != 3'b000) begin
                     // Preempted owner still wants the LEDs: resume its slice
                     // from the frozen count.
                     state_d = ST_SERVE;
                     grant_d = saved_q;
                  end else begin
                     // Owner let go during the flash (or there was none), so
                     // the interrupted slot ends here.
                     slot_done_d = |saved_q;
                     slice_cnt_d = '0;
                     if (win_vld) begin
                        state_d = ST_SERVE;
                        grant_d = win_oh;
                        last_d  = win_idx;
                     end else begin
                        state_d = ST_IDLE;
                        grant_d = 3'b000;
                     end
                  end
                  saved_d = 3'b000;
                  led_d   = pick_led(grant_d, bus.src0_led, bus.src1_led, bus.src2_led);
               end else begin
                  flash_cnt_d = flash_cnt_q + 1'b1;
               end
            end

            default: begin
               state_d = ST_IDLE;
               grant_d = 3'b000;
               led_d   = 8'h00;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         grant_q     <= 3'b000;
         saved_q     <= 3'b000;
         slot_done_q <= 1'b0;
         led_q       <= 8'h00;
         last_q      <= 2'd2;
         slice_cnt_q <= '0;
         flash_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         saved_q     <= saved_d;
         slot_done_q <= slot_done_d;
         led_q       <= led_d;
         last_q      <= last_d;
         slice_cnt_q <= slice_cnt_d;
         flash_cnt_q <= flash_cnt_d;
      end
   end

   assign bus.grant     = grant_q;
   assign bus.slot_done = slot_done_q;
   assign bus.led       = led_q;

endmodule

// File: tb/tb_led_scheduler.sv
// ---------------------------------------------------------------------------
// tb_led_scheduler
// Directed bench for led_scheduler with SLICE_CYCLES=8, FLASH_CYCLES=4.
// A vector table covers reset, first grant and flash restart from idle;
// hand-written sequences cover round-robin, early release, flash preempt /
// resume, release during flash and reset during flash.
// ---------------------------------------------------------------------------
module tb_led_scheduler;

   localparam int SLICE = 8;
   localparam int FLASH = 4;

   localparam logic [7:0] S0 = 8'h58;
   localparam logic [7:0] S1 = 8'h31;
   localparam logic [7:0] S2 = 8'hC3;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   led_scheduler_if bus ();

   led_scheduler #(
      .SLICE_CYCLES (SLICE),
      .FLASH_CYCLES (FLASH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic       rst;
      logic [2:0] req;
      logic       fl;
      logic [7:0] pat;
      logic [2:0] eg;
      logic       esd;
      logic [7:0] el;
   } vec_t;

   vec_t vecs[15];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [2:0] eg, input logic esd,
                      input logic [7:0] el);
      checks++;
      if (bus.grant !== eg || bus.slot_done !== esd || bus.led !== el) begin
         failures++;
         $display("FAIL %s: got grant=%b slot_done=%b led=%h, want grant=%b slot_done=%b led=%h",
                  nm, bus.grant, bus.slot_done, bus.led, eg, esd, el);
      end
   endtask

   task automatic do_reset();
      rst               = 1'b1;
      bus.req           = 3'b000;
      bus.flash_req     = 1'b0;
      bus.flash_pattern = 8'h00;
      step();
      step();
      rst = 1'b0;
   endtask

   logic [2:0] rr_g[4];
   logic [7:0] rr_l[4];

   initial begin
      checks            = 0;
      failures          = 0;
      rst               = 1'b1;
      bus.req           = 3'b000;
      bus.src0_led      = S0;
      bus.src1_led      = S1;
      bus.src2_led      = S2;
      bus.flash_req     = 1'b0;
      bus.flash_pattern = 8'h00;

      // rst  req     fl    pat     grant   sd    led
      vecs[0]  = '{1'b1, 3'b111, 1'b0, 8'h00, 3'b000, 1'b0, 8'h00};
      vecs[1]  = '{1'b1, 3'b111, 1'b0, 8'h00, 3'b000, 1'b0, 8'h00};
      vecs[2]  = '{1'b0, 3'b111, 1'b0, 8'h00, 3'b001, 1'b0, 8'h00};
      vecs[3]  = '{1'b0, 3'b111, 1'b0, 8'h00, 3'b001, 1'b0, S0};
      vecs[4]  = '{1'b1, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0, 8'h00};
      vecs[5]  = '{1'b0, 3'b000, 1'b1, 8'h0F, 3'b000, 1'b0, 8'h0F};
      vecs[6]  = '{1'b0, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0, 8'h0F};
      vecs[7]  = '{1'b0, 3'b000, 1'b1, 8'hF0, 3'b000, 1'b0, 8'hF0};
      vecs[8]  = '{1'b0, 3'b000, 1'b0, 8'hFF, 3'b000, 1'b0, 8'hF0};
      vecs[9]  = '{1'b0, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0, 8'hF0};
      vecs[10] = '{1'b0, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0, 8'hF0};
      vecs[11] = '{1'b0, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0, 8'h00};
      vecs[12] = '{1'b0, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0, 8'h00};
      vecs[13] = '{1'b1, 3'b111, 1'b1, 8'h55, 3'b000, 1'b0, 8'h00};
      vecs[14] = '{1'b0, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0, 8'h00};

      for (int i = 0; i < 15; i++) begin
         rst               = vecs[i].rst;
         bus.req           = vecs[i].req;
         bus.flash_req     = vecs[i].fl;
         bus.flash_pattern = vecs[i].pat;
         step();
         chk($sformatf("vec%0d", i), vecs[i].eg, vecs[i].esd, vecs[i].el);
      end

      // Round-robin with all three requesting: 8 cycles per slot, no gap.
      rr_g[0] = 3'b001; rr_g[1] = 3'b010; rr_g[2] = 3'b100; rr_g[3] = 3'b001;
      rr_l[0] = S0;     rr_l[1] = S1;     rr_l[2] = S2;     rr_l[3] = S0;
      do_reset();
      bus.req = 3'b111;
      step();
      for (int s = 0; s < 4; s++) begin
         for (int c = 0; c < SLICE; c++) begin
            chk($sformatf("rr_s%0d_c%0d", s, c), rr_g[s], (c == 0 && s > 0),
                (c == 0) ? ((s == 0) ? 8'h00 : rr_l[s-1]) : rr_l[s]);
            step();
         end
      end

      // Early release: src1 drops at count 3; src1 pattern changes mid-slot.
      do_reset();
      bus.req = 3'b010;
      step();
      bus.req = 3'b110;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("rel_k%0d", k), 3'b010, 1'b0,
             (k == 0) ? 8'h00 : ((k == 1) ? S1 : 8'h77));
         if (k == 1) bus.src1_led = 8'h77;
         if (k == 3) bus.req = 3'b100;
         step();
      end
      chk("rel_edge", 3'b100, 1'b1, 8'h77);
      bus.src1_led = S1;
      step();
      chk("rel_after", 3'b100, 1'b0, S2);

      // Flash preempt at count 5, resume for 3 cycles, expire to src1.
      do_reset();
      bus.req = 3'b001;
      step();
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("pre_k%0d", k), 3'b001, 1'b0, (k == 0) ? 8'h00 : S0);
         if (k == 5) begin
            bus.flash_req     = 1'b1;
            bus.flash_pattern = 8'hAA;
            bus.req           = 3'b011;
         end
         step();
      end
      bus.flash_req     = 1'b0;
      bus.flash_pattern = 8'h00;
      for (int k = 0; k < FLASH; k++) begin
         chk($sformatf("fl_k%0d", k), 3'b000, 1'b0, 8'hAA);
         step();
      end
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("resume_k%0d", k), 3'b001, 1'b0, S0);
         step();
      end
      chk("resume_expire", 3'b010, 1'b1, S0);
      step();
      chk("resume_next", 3'b010, 1'b0, S1);

      // Owner releases during flash: slot_done on the exit edge, src2 next.
      do_reset();
      bus.req = 3'b001;
      step();
      bus.flash_req     = 1'b1;
      bus.flash_pattern = 8'h3C;
      bus.req           = 3'b100;
      step();
      bus.flash_req = 1'b0;
      for (int k = 0; k < FLASH; k++) begin
         chk($sformatf("flrel_k%0d", k), 3'b000, 1'b0, 8'h3C);
         step();
      end
      chk("flrel_exit", 3'b100, 1'b1, S2);

      // Reset during flash, then src0 must be granted first again.
      do_reset();
      bus.req = 3'b111;
      step();
      step();
      bus.flash_req     = 1'b1;
      bus.flash_pattern = 8'hAA;
      step();
      bus.flash_req = 1'b0;
      chk("rstfl_in_flash", 3'b000, 1'b0, 8'hAA);
      step();
      rst = 1'b1;
      step();
      chk("rstfl_reset", 3'b000, 1'b0, 8'h00);
      rst = 1'b0;
      step();
      chk("rstfl_grant0", 3'b001, 1'b0, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/led_scheduler.md
# led_scheduler

Time-slice scheduler that shares the board's 8-LED bank among three display sources: letter scroller, equalizer band meter and debug status. It also supports a preemptive one-shot flash pattern. Sits between the source blocks and the top-level LED pins and replaces the direct hard-wired LED drive. Round-robin grant with a fixed slice length, early release on request drop, and flash preemption that freezes and then resumes the interrupted slice.

## Interface
- SLICE_CYCLES, default 275_500_000: grant length per slot in clk cycles (5.51 s at 50 MHz); legal range is 2 or more.
- FLASH_CYCLES, default 25_000_000: flash display length in cycles (0.5 s); legal range is 2 or more.
- clk  in  1  system clock, 50 MHz.
- rst  in  1  reset, synchronous, active-high.
- req  in  3  per-source display request; level-sensitive, held while the source wants the LEDs.
- src0_led, src1_led, src2_led  in  8 each  per-source LED pattern, sampled every cycle while granted.
- flash_req  in  1  single-cycle pulse requesting a flash.
- flash_pattern  in  8  pattern to flash, sampled only when flash_req=1.
- grant  out  3  one-hot registered grant; all zeros when nothing is granted.
- slot_done  out  1  one-cycle registered pulse when a slot ends, by expiry or by release.
- LED  out  8  registered LED drive.

## Operation
- States: IDLE, SERVE, FLASH.
- Arbiter (combinational):
  - Round-robin pointer `last` holds the index of the last-served source; reset value is 2, so src0 wins first.
  - Search order is last+1, last+2, last (mod 3).
- IDLE:
  - grant=0 and LED loads 0.
  - If any req is high, next state is SERVE, grant is the arbiter winner, the slice counter clears, and `last` becomes the winner.
- SERVE:
  - LED loads the granted src pattern every cycle.
  - The slice counter increments each cycle up to SLICE_CYCLES-1.
  - Expiry (count=SLICE_CYCLES-1 and req still high):
    - At the next edge, slot_done=1.
    - If any req is high, the arbiter re-runs immediately with no idle gap; the same source is re-granted only if it is the sole requester.
    - If no req is high, go to IDLE.
  - Release (req[granted]=0 in any SERVE cycle): at the next edge grant drops or moves, slot_done=1, and arbitration proceeds as at expiry.
- FLASH:
  - Entry: flash_req=1 in any state. At the next edge the state becomes FLASH, LED loads flash_pattern, grant=0, and the slice counter and saved grant are frozen.
  - FLASH lasts exactly FLASH_CYCLES cycles.
  - flash_req during FLASH restarts the flash counter and loads the new pattern.
- FLASH exit:
  - If the saved grant's req is still high, return to SERVE with that grant and continue the slice from its frozen count.
  - Otherwise, run the arbiter: a winner goes to SERVE with a new slice; no requester goes to IDLE.
  - slot_done does not pulse on flash entry or exit. It pulses on the exit edge only if the preempted source has released.
- Counters are sized to $clog2 of the maximum count. Counters never wrap: they clear on slot start and on flash restart.
- Reset values: grant=0, slot_done=0, LED=0, state=IDLE, last=2, both counters 0. Reset asserted mid-slice or mid-flash forces these at the next edge. Reset has priority over flash_req.

## Timing
- Request to grant: req rises in cycle n (state IDLE), grant is valid at n+1, and LED shows the src data at n+2.
- LED latency: one cycle from src_led to LED while granted.
- Full slice: grant is high for exactly SLICE_CYCLES consecutive cycles, excluding frozen flash cycles.
- slot_done: asserted in the first cycle after the last grant cycle of a slot.
- Flash: flash_req in cycle n gives LED=flash_pattern during n+1 … n+FLASH_CYCLES. The granted data or 0 reloads at edge n+FLASH_CYCLES+1.
- Simultaneous events in one cycle:
  - Flash beats expiry and release; the expiry or release is then evaluated at flash exit.
  - Release and expiry together produce a single slot_done.

## Test plan
Bench parameters: SLICE_CYCLES=8, FLASH_CYCLES=4.
- Reset: rst held 2 cycles while req=3'b111 → grant=0, LED=0, slot_done=0. After release, grant=001 at the first edge and LED=src0_led (e.g. 8'h58) one cycle later.
- Round-robin: req=3'b111 held → grant sequence 001,010,100,001, with 8 cycles each, slot_done pulses on every transition, and no zero-grant gap.
- Early release: src1 granted, req[1] dropped at count 3 → next edge grant=100 and slot_done=1; src1 received exactly 4 grant cycles.
- Flash preempt and resume: src0 at count 5, flash_req with pattern 8'hAA → LED=AA for 4 cycles and grant=0, then grant=001 for exactly 3 more cycles and slot_done.
- Flash restart and flash in IDLE: flash_req in IDLE with 8'h0F, then again 2 cycles later with 8'hF0 → LED=0F for 2 cycles, then F0 for 4 cycles, then return to IDLE with LED=0.
- Sync reset mid-flash: rst during FLASH → all outputs at reset values at the next edge, and src0 is granted first afterwards.
